// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: IF-stage program counter with branch/jump select, run/step/halt control and optional fetch trace
// Ports: i_clock/i_reset (sync, active-high); i_enable, i_step_mode, i_step_req from the debug unit;
// i_stall from the stall unit; i_branch_taken/i_branch_target, i_jump/i_jump_target redirects;
// i_halt decoded HALT; o_pc, o_pc_next_seq, o_advance, o_step_ack, o_halted;
// i_trace_idx, o_trace_pc, o_trace_count are live only when PC_TRACE_EN is defined, tied to 0 otherwise.
module pc_fetch_unit #(
  parameter int unsigned        PC_SIZE     = 32,
  parameter logic [PC_SIZE-1:0] PC_INC      = 4,
  parameter logic [PC_SIZE-1:0] RESET_PC    = '0,
  parameter int unsigned        TRACE_DEPTH = 8
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_enable,
  input  logic                           i_step_mode,
  input  logic                           i_step_req,
  input  logic                           i_stall,
  input  logic                           i_branch_taken,
  input  logic [PC_SIZE-1:0]             i_branch_target,
  input  logic                           i_jump,
  input  logic [PC_SIZE-1:0]             i_jump_target,
  input  logic                           i_halt,
  output logic [PC_SIZE-1:0]             o_pc,
  output logic [PC_SIZE-1:0]             o_pc_next_seq,
  output logic                           o_advance,
  output logic                           o_step_ack,
  output logic                           o_halted,
  input  logic [$clog2(TRACE_DEPTH)-1:0] i_trace_idx,
  output logic [PC_SIZE-1:0]             o_trace_pc,
  output logic [$clog2(TRACE_DEPTH):0]   o_trace_count
);
  typedef enum logic [1:0] {RUN, STEP_IDLE, STEP_WAIT, HALTED} state_t;
  state_t state_q, state_d;
  logic [PC_SIZE-1:0] pc_q, pc_d;
  logic step_ack_q, step_ack_d, grant;
  assign o_pc = pc_q;
  assign o_pc_next_seq = pc_q + PC_INC;
  assign o_step_ack = step_ack_q;
  assign o_halted = state_q == HALTED;
  // grant = the PC would move this cycle if no HALT were decoded; a halting grant still acks a step
  always_comb begin
    grant = ~i_stall & (state_q == RUN ? i_enable : state_q == STEP_IDLE ? i_step_req : 1'b0);
    o_advance = grant & ~i_halt;
    pc_d = ~o_advance ? pc_q : i_branch_taken ? i_branch_target : i_jump ? i_jump_target : o_pc_next_seq;
    step_ack_d = grant & (state_q == STEP_IDLE);
    state_d = state_q;
    case (state_q)
      RUN:       state_d = grant & i_halt ? HALTED : i_step_mode ? STEP_IDLE : RUN;
      STEP_IDLE: state_d = grant ? (i_halt ? HALTED : STEP_WAIT) : i_step_mode ? STEP_IDLE : RUN;
      STEP_WAIT: state_d = i_step_req ? STEP_WAIT : STEP_IDLE;
      default:   state_d = HALTED;
    endcase
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      step_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      step_ack_q <= step_ack_d;
    end
  end
`ifdef PC_TRACE_EN
  localparam int IW = $clog2(TRACE_DEPTH);
  logic [PC_SIZE-1:0] trace_mem_q [TRACE_DEPTH];
  logic [PC_SIZE-1:0] trace_mem_d [TRACE_DEPTH];
  logic [IW-1:0] wptr_q, wptr_d, rd_idx;
  logic [IW:0] count_q, count_d;
  // entries past the valid count read as 0, so the memory itself needs no reset
  always_comb begin
    trace_mem_d = trace_mem_q;
    if (o_advance) trace_mem_d[wptr_q] = pc_d;
    wptr_d = o_advance ? wptr_q + 1'b1 : wptr_q;
    count_d = o_advance && count_q != (IW+1)'(TRACE_DEPTH) ? count_q + 1'b1 : count_q;
    rd_idx = wptr_q - 1'b1 - i_trace_idx;
    o_trace_pc = {1'b0, i_trace_idx} < count_q ? trace_mem_q[rd_idx] : '0;
  end
  assign o_trace_count = count_q;
  always_ff @(posedge i_clock) trace_mem_q <= trace_mem_d;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      count_q <= count_d;
    end
  end
`else
  logic unused_trace_idx;
  assign unused_trace_idx = ^i_trace_idx;
  assign o_trace_pc = '0;
  assign o_trace_count = '0;
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed stimulus with a behavioural fetch model checked every cycle
module tb_pc_fetch_unit;
  localparam int DEPTH = 8;
  logic i_clock = 0, i_reset = 1, i_enable = 0, i_step_mode = 0, i_step_req = 0, i_stall = 0;
  logic i_branch_taken = 0, i_jump = 0, i_halt = 0;
  logic [31:0] i_branch_target = 0, i_jump_target = 0;
  logic [2:0] i_trace_idx = 0;
  logic [31:0] o_pc, o_pc_next_seq, o_trace_pc;
  logic o_advance, o_step_ack, o_halted;
  logic [3:0] o_trace_count;
  int checks = 0, errors = 0, acks;
  bit m_valid = 0, m_halted, m_stepping, m_used, m_ack, g;
  logic [31:0] m_pc;
  logic [31:0] m_tq[$];
  always #5 i_clock = ~i_clock;
  pc_fetch_unit dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_step_mode(i_step_mode),
    .i_step_req(i_step_req), .i_stall(i_stall), .i_branch_taken(i_branch_taken),
    .i_branch_target(i_branch_target), .i_jump(i_jump), .i_jump_target(i_jump_target),
    .i_halt(i_halt), .o_pc(o_pc), .o_pc_next_seq(o_pc_next_seq), .o_advance(o_advance),
    .o_step_ack(o_step_ack), .o_halted(o_halted), .i_trace_idx(i_trace_idx),
    .o_trace_pc(o_trace_pc), .o_trace_count(o_trace_count)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(negedge i_clock);
    i_trace_idx = i_trace_idx + 1'b1;
  endtask
  function automatic bit m_grant();
    return !m_halted && !i_stall && (m_stepping ? (i_step_req && !m_used) : i_enable);
  endfunction
  always @(posedge i_clock) begin
    if (i_reset) begin
      m_valid = 1; m_pc = 0; m_halted = 0; m_ack = 0; m_stepping = 0; m_used = 0;
      m_tq.delete();
    end else if (m_valid) begin
      g = m_grant();
      m_ack = m_stepping && g;
      if (g && i_halt) m_halted = 1;
      else if (g) begin
        m_pc = i_branch_taken ? i_branch_target : i_jump ? i_jump_target : m_pc + 32'd4;
        m_tq.push_front(m_pc);
        if (m_tq.size() > DEPTH) void'(m_tq.pop_back());
      end
      if (!m_halted) begin
        if (m_used) m_used = i_step_req;
        else if (m_stepping && g) m_used = 1;
        else m_stepping = i_step_mode;
      end
    end
  end
  initial forever begin
    @(negedge i_clock);
    #3;
    if (m_valid) begin
      chk("pc", o_pc, m_pc);
      chk("pc_next_seq", o_pc_next_seq, m_pc + 32'd4);
      chk("advance", 32'(o_advance), 32'(m_grant() && !i_halt));
      chk("step_ack", 32'(o_step_ack), 32'(m_ack));
      chk("halted", 32'(o_halted), 32'(m_halted));
`ifdef PC_TRACE_EN
      chk("trace_count", 32'(o_trace_count), m_tq.size());
      chk("trace_pc", o_trace_pc, i_trace_idx < m_tq.size() ? m_tq[i_trace_idx] : 32'd0);
`else
      chk("trace_count", 32'(o_trace_count), 0);
      chk("trace_pc", o_trace_pc, 0);
`endif
    end
  end
  initial begin
    cyc();
    i_reset = 0; i_enable = 1;
    chk("reset_pc", o_pc, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("seq_pc", o_pc, 32'(4 * i));
    end
    i_reset = 1; cyc(); i_reset = 0;
    chk("rerst_pc", o_pc, 0);
    repeat (4) cyc();
    chk("pc_0x10", o_pc, 32'h10);
    i_stall = 1; i_branch_taken = 1; i_branch_target = 32'h200; i_jump = 1; i_jump_target = 32'h300;
    cyc();
    chk("stall_hold", o_pc, 32'h10);
    i_stall = 0; cyc();
    chk("branch_prio", o_pc, 32'h200);
    i_branch_taken = 0; cyc();
    chk("jump", o_pc, 32'h300);
    i_jump_target = 32'h20; cyc();
    i_jump = 0; i_enable = 0;
    chk("pc_0x20", o_pc, 32'h20);
    i_step_mode = 1; cyc();
    i_step_req = 1; acks = 0;
    repeat (5) begin cyc(); acks += int'(o_step_ack); end
    chk("step_once_pc", o_pc, 32'h24);
    chk("step_once_ack", acks, 1);
    i_step_req = 0; cyc();
    i_step_req = 1; cyc();
    chk("step2_pc", o_pc, 32'h28);
    chk("step2_ack", 32'(o_step_ack), 1);
    i_step_req = 0; cyc();
    i_stall = 1; i_step_req = 1;
    repeat (3) begin
      cyc();
      chk("stall_step_pc", o_pc, 32'h28);
      chk("stall_step_ack", 32'(o_step_ack), 0);
    end
    i_stall = 0; cyc();
    chk("unstall_pc", o_pc, 32'h2c);
    chk("unstall_ack", 32'(o_step_ack), 1);
    i_step_req = 0; i_step_mode = 0; cyc(); cyc();
    i_enable = 1; i_jump = 1; i_jump_target = 32'h40; cyc();
    i_jump = 0;
    chk("pc_0x40", o_pc, 32'h40);
    i_stall = 1; i_halt = 1; cyc();
    chk("halt_stalled_pc", o_pc, 32'h40);
    chk("halt_stalled_flag", 32'(o_halted), 0);
    i_stall = 0; #1;
    chk("halt_no_adv", 32'(o_advance), 0);
    cyc();
    chk("halt_pc", o_pc, 32'h40);
    chk("halt_flag", 32'(o_halted), 1);
    i_halt = 0; i_branch_taken = 1; i_branch_target = 32'h100;
    repeat (3) cyc();
    chk("halted_pc", o_pc, 32'h40);
    chk("halted_flag", 32'(o_halted), 1);
    i_branch_taken = 0; i_reset = 1; cyc(); i_reset = 0;
    chk("halt_rst_flag", 32'(o_halted), 0);
    chk("halt_rst_pc", o_pc, 0);
    i_enable = 0; i_step_mode = 1; cyc();
    i_step_req = 1; i_halt = 1; cyc();
    chk("halt_step_ack", 32'(o_step_ack), 1);
    chk("halt_step_flag", 32'(o_halted), 1);
    chk("halt_step_pc", o_pc, 0);
    i_step_req = 0; i_halt = 0; i_step_mode = 0; i_reset = 1; cyc(); i_reset = 0;
    chk("step_rst_flag", 32'(o_halted), 0);
    i_enable = 1; i_jump = 1; i_jump_target = 32'hffff_fffc; cyc();
    i_jump = 0;
    chk("wrap_pre", o_pc, 32'hffff_fffc);
    chk("wrap_seq", o_pc_next_seq, 0);
    cyc();
    chk("wrap_pc", o_pc, 0);
    i_reset = 1; cyc(); i_reset = 0;
    repeat (10) cyc();
    i_enable = 0;
    chk("trace_run_pc", o_pc, 40);
    i_trace_idx = 0; #1;
`ifdef PC_TRACE_EN
    chk("trace_cnt8", 32'(o_trace_count), 8);
    chk("trace_idx0", o_trace_pc, 40);
    i_trace_idx = 7; #1;
    chk("trace_idx7", o_trace_pc, 12);
`else
    chk("trace_cnt_off", 32'(o_trace_count), 0);
    chk("trace_pc_off", o_trace_pc, 0);
`endif
    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
